tb_mem_arbiter: RTL

TB_MEM_ARBITER -- requirements
Module: tb_mem_arbiter

---
 rtl/tb_mem_arbiter_if.sv | 43 ++++
 rtl/tb_mem_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/tb_mem_arbiter_if.sv
// Bundle of requester-side and RAM-side signals for the two-requester memory arbiter.
// slave: arbiter view; master: requester/RAM model view.
interface tb_mem_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 22,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   logic                  m0_req_i,    m1_req_i;
   logic [ADDR_WIDTH-1:0] m0_addr_i,   m1_addr_i;
   logic                  m0_we_i,     m1_we_i;
   logic [BE_WIDTH-1:0]   m0_be_i,     m1_be_i;
   logic [DATA_WIDTH-1:0] m0_wdata_i,  m1_wdata_i;
   logic                  m0_gnt_o,    m1_gnt_o;
   logic                  m0_rvalid_o, m1_rvalid_o;
   logic [DATA_WIDTH-1:0] m0_rdata_o,  m1_rdata_o;
   logic [31:0]           m0_gnt_cnt_o, m1_gnt_cnt_o;

   logic                  ram_req_o;
   logic [ADDR_WIDTH-1:0] ram_addr_o;
   logic                  ram_we_o;
   logic [BE_WIDTH-1:0]   ram_be_o;
   logic [DATA_WIDTH-1:0] ram_wdata_o;
   logic [DATA_WIDTH-1:0] ram_rdata_i;

   modport slave (
      input  m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
      input  m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
      output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_gnt_cnt_o,
      output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_gnt_cnt_o,
      output ram_req_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o,
      input  ram_rdata_i
   );

   modport master (
      output m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
      output m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
      input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_gnt_cnt_o,
      input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_gnt_cnt_o,
      input  ram_req_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o,
      output ram_rdata_i
   );
endinterface

// File: rtl/tb_mem_arbiter.sv
// Two-requester arbiter onto one single-cycle RAM port, round-robin on contention.
// Define TB_MEM_ARB_FIXED_PRIO_EN to make requester 0 always win contention instead.
module tb_mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 22,
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic             clk_i,
   input logic             rst_i,
   tb_mem_arbiter_if.slave bus
);
   localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
   localparam int unsigned CNT_WIDTH = 32;

   logic                  gnt0_c, gnt1_c;
   logic                  favour0_c;
   logic                  rv0_c, rv1_c;
   logic                  owner_q, owner_vld_q;
   logic [CNT_WIDTH-1:0]  cnt0_q, cnt1_q;
   logic [ADDR_WIDTH-1:0] addr_c;
   logic                  we_c;
   logic [BE_WIDTH-1:0]   be_c;
   logic [DATA_WIDTH-1:0] wdata_c;

`ifdef TB_MEM_ARB_FIXED_PRIO_EN
   assign favour0_c = 1'b1;
`else
   // last_q = 1 means requester 0 held the most recent grant; reset (0) favours requester 0
   logic last_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)                 last_q <= 1'b0;
      else if (gnt0_c || gnt1_c) last_q <= gnt0_c;
   end

   assign favour0_c = ~last_q;
`endif

   // Combinational grant, suppressed during reset
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (!rst_i) begin
         if (bus.m0_req_i && bus.m1_req_i) begin
            gnt0_c = favour0_c;
            gnt1_c = ~favour0_c;
         end else begin
            gnt0_c = bus.m0_req_i;
            gnt1_c = bus.m1_req_i;
         end
      end
   end

   // RAM command mux, zero when idle
   always_comb begin
      addr_c  = '0;
      we_c    = 1'b0;
      be_c    = '0;
      wdata_c = '0;
      if (gnt0_c) begin
         addr_c  = bus.m0_addr_i;
         we_c    = bus.m0_we_i;
         be_c    = bus.m0_be_i;
         wdata_c = bus.m0_wdata_i;
      end else if (gnt1_c) begin
         addr_c  = bus.m1_addr_i;
         we_c    = bus.m1_we_i;
         be_c    = bus.m1_be_i;
         wdata_c = bus.m1_wdata_i;
      end
   end

   // Response owner tracking and per-requester grant counters
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         owner_vld_q <= 1'b0;
         owner_q     <= 1'b0;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
      end else begin
         owner_vld_q <= gnt0_c | gnt1_c;
         owner_q     <= gnt1_c;
         if (gnt0_c) cnt0_q <= cnt0_q + CNT_WIDTH'(1);
         if (gnt1_c) cnt1_q <= cnt1_q + CNT_WIDTH'(1);
      end
   end

   // A response due while reset is asserted is dropped
   assign rv0_c = owner_vld_q & ~owner_q & ~rst_i;
   assign rv1_c = owner_vld_q &  owner_q & ~rst_i;

   assign bus.m0_gnt_o     = gnt0_c;
   assign bus.m1_gnt_o     = gnt1_c;
   assign bus.m0_rvalid_o  = rv0_c;
   assign bus.m1_rvalid_o  = rv1_c;
   assign bus.m0_rdata_o   = rv0_c ? bus.ram_rdata_i : '0;
   assign bus.m1_rdata_o   = rv1_c ? bus.ram_rdata_i : '0;
   assign bus.m0_gnt_cnt_o = cnt0_q;
   assign bus.m1_gnt_cnt_o = cnt1_q;
   assign bus.ram_req_o    = gnt0_c | gnt1_c;
   assign bus.ram_addr_o   = addr_c;
   assign bus.ram_we_o     = we_c;
   assign bus.ram_be_o     = be_c;
   assign bus.ram_wdata_o  = wdata_c;
endmodule
